seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 137 +++++++++++++
 tb/tb_seg7_scan.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner with frame snapshot and registered outputs.
// Optional leading-zero suppression: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_TERM = PW'(REFRESH_DIV - 1);
    localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          presc_term;
    logic          snap_load;
    logic [15:0]   snap_eff;
    logic [3:0]    digit;
    logic          slot_lz;
    logic [3:0]    an_raw;
    logic [6:0]    seg_raw;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] s;
        s = 7'h00;
        unique case (code)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_term = (presc_q == PRESC_TERM);
        snap_load  = (presc_q == '0) && (idx_q == 2'd0);
        presc_d    = presc_term ? '0 : presc_q + PW'(1);
        idx_d      = presc_term ? idx_q + 2'd1 : idx_q;
    end

    // The loading cycle decodes the fresh inputs so slot 0 is consistent
    // for its whole duration rather than showing stale data for one cycle.
    always_comb begin
        snap_eff = snap_load ? {thousands, hundreds, tens, ones} : snap_q;
        snap_d   = snap_eff;
    end

    always_comb begin
        digit = 4'd0;
        unique case (idx_q)
            2'd0: digit = snap_eff[3:0];
            2'd1: digit = snap_eff[7:4];
            2'd2: digit = snap_eff[11:8];
            2'd3: digit = snap_eff[15:12];
            default: digit = 4'd0;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        slot_lz = 1'b0;
        unique case (idx_q)
            2'd0: slot_lz = 1'b0;
            2'd1: slot_lz = (snap_eff[15:8] == 8'h00);
            2'd2: slot_lz = (snap_eff[15:8] == 8'h00);
            2'd3: slot_lz = (snap_eff[15:12] == 4'h0);
            default: slot_lz = 1'b0;
        endcase
        if (idx_q == 2'd1) begin
            slot_lz = (snap_eff[15:4] == 12'h000);
        end
    end
`else
    always_comb begin
        slot_lz = 1'b0;
    end
`endif

    always_comb begin
        an_raw  = 4'b0000;
        seg_raw = 7'h00;
        if (!blank && !slot_lz) begin
            an_raw  = 4'b0001 << idx_q;
            seg_raw = bcd_to_seg(digit);
        end
        an_d  = an_raw ^ AN_POL;
        seg_d = seg_raw ^ SEG_POL;
        dp_d  = ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 16'h0000;
            an_q    <= AN_POL;
            seg_q   <= SEG_POL;
            dp_q    <= ACTIVE_LOW;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a frame-level reference model predicts each
// output cycle, a separate monitor compares it against the DUT.
module tb_seg7_scan;

    localparam int DIV = 4;
    localparam bit AL  = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0, thousands = 4'd0;
    logic       blank = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(AL)) dut (
        .clk(clk), .reset(reset),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .blank(blank), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit active = 1'b0;
    logic [11:0] exp_q[$];
    int cyc_q[$];

    logic [6:0] seg_tab [16];
    int         t_model;
    int         cyc_no = 0;
    logic [3:0] snap [4];
    logic [3:0] cur [4];

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B;
        seg_tab[3] = 7'h4F; seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D;
        seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07; seg_tab[8] = 7'h7F;
        seg_tab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h00;
    end

    function automatic bit lz_blanked(input int slot);
        bit upper_nz;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        upper_nz = 1'b0;
        for (int k = slot; k < 4; k++) if (snap[k] != 4'd0) upper_nz = 1'b1;
        return (slot != 0) && !upper_nz;
`else
        upper_nz = 1'b1;
        return !upper_nz;
`endif
    endfunction

    // One clock: drive inputs, predict the output that follows this edge.
    task automatic cyc(input bit r, input bit b);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        int slot;
        @(negedge clk);
        reset = r;
        blank = b;
        ones = cur[0]; tens = cur[1]; hundreds = cur[2]; thousands = cur[3];
        e_an = 4'b0000;
        e_seg = 7'h00;
        if (r) begin
            t_model = 0;
        end else begin
            if (t_model % (4 * DIV) == 0) begin
                for (int k = 0; k < 4; k++) snap[k] = cur[k];
            end
            slot = (t_model / DIV) % 4;
            if (!b && !lz_blanked(slot)) begin
                e_an = 4'(1 << slot);
                e_seg = seg_tab[snap[slot]];
            end
            t_model++;
        end
        exp_q.push_back({e_an, e_seg, 1'b0} ^ {12{AL}});
        cyc_q.push_back(cyc_no);
        cyc_no++;
        active = 1'b1;
    endtask

    task automatic run(input int n, input bit b);
        for (int i = 0; i < n; i++) cyc(1'b0, b);
    endtask

    task automatic set_digits(input int th, input int hu, input int te, input int on);
        cur[3] = 4'(th); cur[2] = 4'(hu); cur[1] = 4'(te); cur[0] = 4'(on);
    endtask

    initial begin : monitor
        logic [11:0] e;
        int c;
        forever begin
            @(posedge clk);
            #1;
            if (active) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underrun: got an=%b seg=%h dp=%b, required a queued prediction",
                             an, seg, dp);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    if ({an, seg, dp} !== e) begin
                        n_fail++;
                        $display("FAIL scan_cycle_%0d: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                                 c, an, seg, dp, e[11:8], e[7:1], e[0]);
                    end
                end
                n_checks++;
                if ($countones(an ^ {4{AL}}) > 1) begin
                    n_fail++;
                    $display("FAIL an_onehot: got an=%b, required at most one active bit", an);
                end
            end
        end
    end

    initial begin : driver
        set_digits(1, 2, 3, 4);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        run(16, 1'b0);
        run(8, 1'b0);
        cur[0] = 4'd7;
        run(8, 1'b0);
        run(16, 1'b0);
        run(5, 1'b0);
        run(6, 1'b1);
        run(13, 1'b0);
        set_digits(0, 0, 0, 4'hC);
        run(32, 1'b0);
        set_digits(0, 0, 4, 2);
        run(32, 1'b0);
        set_digits(0, 0, 0, 0);
        run(32, 1'b0);
        set_digits(0, 5, 0, 9);
        run(32, 1'b0);
        set_digits(1, 2, 3, 4);
        run(16 + 2 * DIV + 1, 1'b0);
        set_digits(9, 8, 7, 6);
        cyc(1'b1, 1'b0);
        run(20, 1'b0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 4; k++)
                    cur[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0);
        end
        @(posedge clk);
        #2;
        active = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
